pc_next_gen: RTL and testbench
==============================

PC_NEXT_GEN -- requirements
Module: pc_next_gen

Interface
REQ-001 Parameter RAS_DEPTH, default 4, return-address-stack entries; legal values 2 and 4 only.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 PCResult  input  32  current PC value from the ProgramCounter register.
REQ-005 Stall  input  1  hold PC; no stack or flag updates.
REQ-006 Branch  input  1  conditional branch taken.
REQ-007 BranchOffset  input  32  sign-extended word offset.
REQ-008 Jump  input  1  absolute jump.
REQ-009 JumpIndex  input  26  jump target word index.
REQ-010 Call  input  1  jump-and-link; implies Jump target, pushes link.
REQ-011 Return  input  1  return; target taken from stack top.
REQ-012 Address  output  32  next PC, drives ProgramCounter Address input; combinational.
REQ-013 Flush  output  1  registered, one-cycle pulse after any redirect.
REQ-014 RasCount  output  3  number of valid stack entries.
REQ-015 RasOverflow  output  1  sticky: push occurred while stack full.
REQ-016 RasUnderflow  output  1  sticky: Return occurred while stack empty.

Function
REQ-017 Request priority: Stall > Return > Call > Jump > Branch > sequential; exactly one action per cycle.
REQ-018 Sequential: Address = PCResult + 4, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 Stall: Address = PCResult; stack, RasCount, flags and Flush input path unchanged (Flush next cycle 0).
REQ-020 Branch: Address = PCResult + 4 + (BranchOffset << 2), modulo 2^32, offset bits shifted out discarded.
REQ-021 Jump and Call: Address = {(PCResult+4)[31:28], JumpIndex, 2'b00}.
REQ-022 Call: pushes link value PCResult + 4 on the same rising edge; RasCount increments by 1.
REQ-023 Call with stack full: oldest entry discarded, new link becomes top, RasCount stays RAS_DEPTH, RasOverflow set.
REQ-024 Return with stack non-empty: Address = top entry; entry popped on the edge; RasCount decrements by 1.
REQ-025 Return with stack empty: Address = PCResult + 4; RasCount stays 0; RasUnderflow set.
REQ-026 Return and Call together: Return wins; pop only, no push.
REQ-027 Call+Return back-to-back cycles: popped value equals value pushed on prior edge (no bypass hazard).
REQ-028 Flush = 1 in the cycle after any non-stalled Branch, Jump, Call or Return (including underflowed Return); otherwise 0.
REQ-029 Redirects in consecutive cycles produce Flush high for consecutive cycles.
REQ-030 RasOverflow and RasUnderflow stay set until Reset; never cleared by other activity.
REQ-031 Stack implemented as circular buffer with top pointer; entries not cleared on pop.

Reset
REQ-032 Reset high asynchronously clears RasCount to 0, top pointer to 0, Flush, RasOverflow, RasUnderflow to 0.
REQ-033 While Reset high, Address = 32'h0000_0000 regardless of other inputs.
REQ-034 Reset asserted mid-sequence (stack partly filled, Flush high) clears all state within same cycle; first post-reset Return underflows.
REQ-035 Stack entry contents need not be cleared by Reset.

Verification
REQ-036 PCResult=32'h0000_0100, no requests -> Address=32'h0000_0104, Flush stays 0; PCResult=32'hFFFF_FFFC -> Address=0.
REQ-037 PCResult=32'h0000_0100, Branch=1, BranchOffset=32'hFFFF_FFFE -> Address=32'h0000_00FC; next cycle Flush=1, then 0.
REQ-038 PCResult=32'h1000_0040, Call=1, JumpIndex=26'h0000_200 -> Address=32'h1000_0800, RasCount=1; later Return=1 -> Address=32'h1000_0044, RasCount=0.
REQ-039 Five Calls at PCResult 0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> RasOverflow=1, RasCount=4; four Returns give 0x54,0x44,0x34,0x24; fifth Return -> Address=PCResult+4, RasUnderflow=1.
REQ-040 Stall=1 with Branch=1 and Return=1, PCResult=32'h0000_0200 -> Address=32'h0000_0200, RasCount unchanged, Flush=0 next cycle.
REQ-041 Two Calls, then Reset pulsed asynchronously between edges -> RasCount, Flush, flags 0 immediately, Address=0 during Reset; first Return after release sets RasUnderflow.

Source files
------------

// File: rtl/pc_next_gen.sv
// Next-PC generator: sequential/branch/jump/call/return target selection with a
// circular return-address stack, a registered redirect flush pulse and sticky stack error flags.
module pc_next_gen #(
   parameter int RAS_DEPTH = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCResult,
   input  logic        Stall,
   input  logic        Branch,
   input  logic [31:0] BranchOffset,
   input  logic        Jump,
   input  logic [25:0] JumpIndex,
   input  logic        Call,
   input  logic        Return,
   output logic [31:0] Address,
   output logic        Flush,
   output logic [2:0]  RasCount,
   output logic        RasOverflow,
   output logic        RasUnderflow
);

   localparam int PW = (RAS_DEPTH == 4) ? 2 : 1;

   generate
      if (RAS_DEPTH != 2 && RAS_DEPTH != 4) begin : g_bad_depth
         $error("pc_next_gen: RAS_DEPTH must be 2 or 4");
      end
   endgenerate

   logic [31:0]   ras_mem [RAS_DEPTH];
   logic [PW-1:0] top_ptr;
   logic [PW-1:0] top_idx;
   logic [2:0]    count;
   logic          flush_q;
   logic          overflow_q;
   logic          underflow_q;

   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] next_pc;
   logic        do_return;
   logic        do_call;
   logic        do_jump;
   logic        do_branch;
   logic        ras_empty;
   logic        ras_full;
   logic        redirect;
   logic        unused_offset_bits;

   assign pc_plus4      = PCResult + 32'd4;
   // Offset bits shifted past bit 31 are dropped, giving modulo-2^32 targets.
   assign branch_target = pc_plus4 + {BranchOffset[29:0], 2'b00};
   assign jump_target   = {pc_plus4[31:28], JumpIndex, 2'b00};
   assign unused_offset_bits = ^BranchOffset[31:30];

   // top_ptr is the next write slot, so the top of stack sits one below it.
   assign top_idx   = top_ptr - PW'(1);
   assign ras_empty = (count == 3'd0);
   assign ras_full  = (count == 3'(RAS_DEPTH));

   always_comb begin
      do_return = 1'b0;
      do_call   = 1'b0;
      do_jump   = 1'b0;
      do_branch = 1'b0;
      next_pc   = pc_plus4;
      if (Stall) begin
         next_pc = PCResult;
      end else if (Return) begin
         do_return = 1'b1;
         if (!ras_empty) next_pc = ras_mem[top_idx];
      end else if (Call) begin
         do_call = 1'b1;
         next_pc = jump_target;
      end else if (Jump) begin
         do_jump = 1'b1;
         next_pc = jump_target;
      end else if (Branch) begin
         do_branch = 1'b1;
         next_pc = branch_target;
      end
   end

   assign redirect = do_return | do_call | do_jump | do_branch;
   assign Address  = Reset ? 32'h0000_0000 : next_pc;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         top_ptr     <= '0;
         count       <= 3'd0;
         flush_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         flush_q <= redirect;
         if (do_return) begin
            if (ras_empty) begin
               underflow_q <= 1'b1;
            end else begin
               top_ptr <= top_idx;
               count   <= count - 3'd1;
            end
         end else if (do_call) begin
            // When full, the slot being written holds the oldest entry.
            top_ptr <= top_ptr + PW'(1);
            if (ras_full) overflow_q <= 1'b1;
            else          count      <= count + 3'd1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset && do_call) ras_mem[top_ptr] <= pc_plus4;
   end

   assign Flush        = flush_q;
   assign RasCount     = count;
   assign RasOverflow  = overflow_q;
   assign RasUnderflow = underflow_q;

endmodule

// File: tb/tb_pc_next_gen.sv
// Directed bench for pc_next_gen: hand-computed next-PC targets, stack behaviour,
// flush pulses, sticky flags and asynchronous reset.
module tb_pc_next_gen;

   logic        Clk;
   logic        Reset;
   logic [31:0] PCResult;
   logic        Stall;
   logic        Branch;
   logic [31:0] BranchOffset;
   logic        Jump;
   logic [25:0] JumpIndex;
   logic        Call;
   logic        Return;
   logic [31:0] Address;
   logic        Flush;
   logic [2:0]  RasCount;
   logic        RasOverflow;
   logic        RasUnderflow;

   int vectors = 0;
   int miscompares = 0;

   pc_next_gen #(.RAS_DEPTH(4)) dut (
      .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Stall(Stall),
      .Branch(Branch), .BranchOffset(BranchOffset), .Jump(Jump),
      .JumpIndex(JumpIndex), .Call(Call), .Return(Return),
      .Address(Address), .Flush(Flush), .RasCount(RasCount),
      .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      Stall = 0; Branch = 0; Jump = 0; Call = 0; Return = 0;
      BranchOffset = '0; JumpIndex = '0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_call(input logic [31:0] pc, input logic [25:0] idx, input logic [31:0] exp_addr,
                          input logic [2:0] exp_cnt, input logic exp_ovf, input string tag);
      idle(); PCResult = pc; Call = 1; JumpIndex = idx;
      #1 check({tag, " addr"}, Address, exp_addr);
      tick();
      check({tag, " count"}, {29'd0, RasCount}, {29'd0, exp_cnt});
      check({tag, " ovf"}, {31'd0, RasOverflow}, {31'd0, exp_ovf});
   endtask

   task automatic do_return(input logic [31:0] pc, input logic [31:0] exp_addr,
                            input logic [2:0] exp_cnt, input logic exp_unf, input string tag);
      idle(); PCResult = pc; Return = 1;
      #1 check({tag, " addr"}, Address, exp_addr);
      tick();
      check({tag, " count"}, {29'd0, RasCount}, {29'd0, exp_cnt});
      check({tag, " unf"}, {31'd0, RasUnderflow}, {31'd0, exp_unf});
      check({tag, " flush"}, {31'd0, Flush}, 32'd1);
   endtask

   initial begin
      idle();
      Reset = 1; PCResult = 32'h0000_0100; Jump = 1; JumpIndex = 26'h3FF_FFFF;
      tick(); tick();
      check("reset addr", Address, 32'h0);
      check("reset count", {29'd0, RasCount}, 32'd0);
      check("reset flush", {31'd0, Flush}, 32'd0);
      check("reset ovf", {31'd0, RasOverflow}, 32'd0);
      check("reset unf", {31'd0, RasUnderflow}, 32'd0);
      Reset = 0; idle();

      // Sequential fetch and wrap
      PCResult = 32'h0000_0100;
      #1 check("seq addr", Address, 32'h0000_0104);
      tick(); check("seq flush", {31'd0, Flush}, 32'd0);
      PCResult = 32'hFFFF_FFFC;
      #1 check("seq wrap", Address, 32'h0000_0000);
      tick();

      // Backward branch
      PCResult = 32'h0000_0100; Branch = 1; BranchOffset = 32'hFFFF_FFFE;
      #1 check("branch addr", Address, 32'h0000_00FC);
      tick(); idle();
      check("branch flush1", {31'd0, Flush}, 32'd1);
      tick(); check("branch flush0", {31'd0, Flush}, 32'd0);

      // Call then return
      do_call(32'h1000_0040, 26'h000_0200, 32'h1000_0800, 3'd1, 1'b0, "call1");
      check("call1 flush", {31'd0, Flush}, 32'd1);
      do_return(32'h1000_0800, 32'h1000_0044, 3'd0, 1'b0, "ret1");
      idle(); tick();
      check("idle flush", {31'd0, Flush}, 32'd0);

      // Jump beats branch; then consecutive redirects keep Flush high
      PCResult = 32'h2000_0010; Jump = 1; JumpIndex = 26'h3FF_FFFF; Branch = 1; BranchOffset = 32'h10;
      #1 check("jump addr", Address, 32'h2FFF_FFFC);
      tick(); idle();
      PCResult = 32'h0000_0300; Branch = 1; BranchOffset = 32'h0000_0001;
      #1 check("branch fwd addr", Address, 32'h0000_0308);
      check("jump flush", {31'd0, Flush}, 32'd1);
      tick();
      check("b2b flush", {31'd0, Flush}, 32'd1);

      // Overflow and drain
      do_call(32'h10, 26'h0, 32'h0, 3'd1, 1'b0, "ov c1");
      do_call(32'h20, 26'h0, 32'h0, 3'd2, 1'b0, "ov c2");
      do_call(32'h30, 26'h0, 32'h0, 3'd3, 1'b0, "ov c3");
      do_call(32'h40, 26'h0, 32'h0, 3'd4, 1'b0, "ov c4");
      do_call(32'h50, 26'h0, 32'h0, 3'd4, 1'b1, "ov c5");
      do_return(32'h100, 32'h54, 3'd3, 1'b0, "ov r1");
      do_return(32'h100, 32'h44, 3'd2, 1'b0, "ov r2");
      do_return(32'h100, 32'h34, 3'd1, 1'b0, "ov r3");
      do_return(32'h100, 32'h24, 3'd0, 1'b0, "ov r4");
      do_return(32'h500, 32'h504, 3'd0, 1'b1, "ov r5");
      check("ovf sticky", {31'd0, RasOverflow}, 32'd1);

      // Return wins over Call; pop sees the value pushed on the prior edge
      do_call(32'h600, 26'h0, 32'h0, 3'd1, 1'b1, "cr c");
      idle(); PCResult = 32'h700; Call = 1; Return = 1; JumpIndex = 26'h123;
      #1 check("cr addr", Address, 32'h604);
      tick();
      check("cr count", {29'd0, RasCount}, 32'd0);

      // Stall overrides everything
      do_call(32'h800, 26'h0, 32'h0, 3'd1, 1'b1, "st c");
      idle(); PCResult = 32'h200; Stall = 1; Branch = 1; Return = 1; BranchOffset = 32'h40;
      #1 check("stall addr", Address, 32'h200);
      tick();
      check("stall count", {29'd0, RasCount}, 32'd1);
      check("stall flush", {31'd0, Flush}, 32'd0);
      do_return(32'h900, 32'h804, 3'd0, 1'b1, "st r");

      // Asynchronous reset between edges with stack partly filled
      do_call(32'h900, 26'h0, 32'h0, 3'd1, 1'b1, "rs c1");
      do_call(32'hA00, 26'h0, 32'h0, 3'd2, 1'b1, "rs c2");
      check("rs flush pre", {31'd0, Flush}, 32'd1);
      idle(); PCResult = 32'h1234; Jump = 1; JumpIndex = 26'h55;
      #2 Reset = 1;
      #1 check("rs count", {29'd0, RasCount}, 32'd0);
      check("rs flush", {31'd0, Flush}, 32'd0);
      check("rs ovf", {31'd0, RasOverflow}, 32'd0);
      check("rs unf", {31'd0, RasUnderflow}, 32'd0);
      check("rs addr", Address, 32'h0);
      tick();
      Reset = 0;
      do_return(32'hB00, 32'hB04, 3'd0, 1'b1, "post rs ret");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
